// File: rtl/ble_fsk_nco_tx_pkg.sv
// ble_tx_pkg: shared defaults and state encoding for the BLE FSK NCO transmitter
package ble_tx_pkg;
   localparam int PHASE_W_DEF = 24;
   localparam int OUT_W_DEF = 8;
   localparam int SPS_DEF = 64;
   localparam int DEV_DEF = 65536;
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/ble_fsk_nco_tx_if.sv
// ble_fsk_nco_tx_if: serial symbol valid/ready stream into the modulator
interface ble_fsk_nco_tx_if;
   logic sym_bit;
   logic sym_last;
   logic sym_valid;
   logic sym_ready;
   modport master(output sym_bit, sym_last, sym_valid, input sym_ready);
   modport slave(input sym_bit, sym_last, sym_valid, output sym_ready);
endinterface

// File: rtl/ble_fsk_nco_tx_phase_acc.sv
// ble_phase_acc: modulo phase accumulator with clear-and-add, enable and registered MSB output
module ble_phase_acc import ble_tx_pkg::*; #(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [PHASE_W-1:0] inc,
   output logic [OUT_W-1:0]   phase_out,
   output logic               phase_valid
);
   logic [PHASE_W-1:0] acc, acc_next;
   // a clear restarts from zero but still applies this cycle's increment
   always_comb acc_next = (clr ? '0 : acc) + inc;
   // advance the phase and publish its MSBs only on generating cycles
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc <= '0;
         phase_out <= '0;
         phase_valid <= 1'b0;
      end else begin
         phase_valid <= en;
         if (en) begin
            acc <= acc_next;
            phase_out <= acc_next[PHASE_W-1 -: OUT_W];
         end
      end
endmodule

// File: rtl/ble_fsk_nco_tx.sv
// ble_fsk_nco_tx: continuous-phase BLE FSK modulator; define BLE_TX_SHAPE_EN for 2-tap frequency shaping
module ble_fsk_nco_tx import ble_tx_pkg::*; #(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int SAMPLES_PER_SYM = SPS_DEF,
   parameter int DEV = DEV_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               LOCK,
   input  logic               rate_2m,
   input  logic [PHASE_W-1:0] fcw_center,
   ble_fsk_nco_tx_if.slave    sym,
   output logic [OUT_W-1:0]   phase_out,
   output logic               phase_valid,
   output logic               busy,
   output logic               lock_err,
   output logic               urun_err,
   input  logic               clr_err
);
   localparam int CW = $clog2(SAMPLES_PER_SYM);
   localparam logic [PHASE_W-1:0] DEV_W = PHASE_W'(DEV);
   state_t state;
   logic [CW-1:0] cnt, sps_m1;
   logic bit_r, last_r, run, bnd, take, start, gen, cur;
   logic [PHASE_W-1:0] off, inc;
`ifdef BLE_TX_SHAPE_EN
   logic prev_r, prev;
`endif
   // handshake, sample-generation decision and per-clock frequency word
   always_comb begin
      run = state == RUN;
      bnd = run && cnt == sps_m1;
      sym.sym_ready = run ? LOCK && bnd && !last_r : LOCK;
      take = sym.sym_valid && sym.sym_ready;
      start = take && !run;
      gen = take || (run && LOCK && !bnd);
      cur = take ? sym.sym_bit : bit_r;
`ifdef BLE_TX_SHAPE_EN
      prev = start ? sym.sym_bit : take ? bit_r : prev_r;
      off = cur != prev ? '0 : cur ? DEV_W : -DEV_W;
`else
      off = cur ? DEV_W : -DEV_W;
`endif
      inc = fcw_center + off;
   end
   // control FSM, symbol counter and sticky error flags
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state <= IDLE;
         cnt <= '0;
         sps_m1 <= '0;
         bit_r <= 1'b0;
         last_r <= 1'b0;
         busy <= 1'b0;
         lock_err <= 1'b0;
         urun_err <= 1'b0;
      end else begin
         if (take) begin
            bit_r <= sym.sym_bit;
            last_r <= sym.sym_last;
            cnt <= '0;
         end else if (run) cnt <= cnt + 1'b1;
         if (start) sps_m1 <= rate_2m ? CW'(SAMPLES_PER_SYM/2 - 1) : CW'(SAMPLES_PER_SYM - 1);
         state <= gen ? RUN : IDLE;
         busy <= gen;
         lock_err <= (run && !LOCK) || (lock_err && !clr_err);
         urun_err <= (bnd && LOCK && !last_r && !sym.sym_valid) || (urun_err && !clr_err);
      end
`ifdef BLE_TX_SHAPE_EN
   // remember the symbol feeding the second shaping tap
   always_ff @(posedge CLK or posedge RST)
      if (RST) prev_r <= 1'b0;
      else if (take) prev_r <= prev;
`endif
   ble_phase_acc #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) u_acc (
      .clk(CLK),
      .rst(RST),
      .clr(start),
      .en(gen),
      .inc(inc),
      .phase_out(phase_out),
      .phase_valid(phase_valid)
   );
endmodule
